// File: rtl/alu_seq_stage.sv
// alu_seq_stage: sequenced ALU stage for a microprogrammed datapath.
// An operation is accepted on start in IDLE. Logic/arithmetic ops take one
// execute cycle. SRL shifts one bit per cycle. The result and flags are
// registered and held until the next operation completes. The done output
// pulses for one cycle, one edge after the DONE state.
module alu_seq_stage #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALU_operation,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             overflow
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_shreg;
   logic [SHW-1:0]   r_cnt;
   logic             r_done;
   logic [WIDTH-1:0] r_res;
   logic             r_zero;
   logic             r_overflow;

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic             w_slt;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf;

   assign busy     = (r_state != ST_IDLE);
   assign done     = r_done;
   assign res      = r_res;
   assign zero     = r_zero;
   assign overflow = r_overflow;

   assign w_sum  = r_a + r_b;
   assign w_diff = r_a - r_b;
   assign w_slt  = ($signed(r_a) < $signed(r_b));

   // Single-cycle result and signed-overflow for the latched operands.
   always_comb begin
      w_res = {WIDTH{1'b0}};
      w_ovf = 1'b0;
      case (r_op)
         OP_AND: w_res = r_a & r_b;
         OP_OR:  w_res = r_a | r_b;
         OP_ADD: begin
            w_res = w_sum;
            // Same-sign operands producing a different-sign result.
            w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_XOR: w_res = r_a ^ r_b;
         OP_NOR: w_res = ~(r_a | r_b);
         OP_SUB: begin
            w_res = w_diff;
            // Subtraction adds ~B, so operand signs must differ to overflow.
            w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
         default: begin
            // SRL never reaches EXEC; keep the result neutral.
            w_res = {WIDTH{1'b0}};
            w_ovf = 1'b0;
         end
      endcase
   end

   // Control sequencer plus result/flag registers; reset discards any op.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_a        <= {WIDTH{1'b0}};
         r_b        <= {WIDTH{1'b0}};
         r_op       <= 3'b000;
         r_shreg    <= {WIDTH{1'b0}};
         r_cnt      <= {SHW{1'b0}};
         r_done     <= 1'b0;
         r_res      <= {WIDTH{1'b0}};
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_op    <= ALU_operation;
                  r_shreg <= B;
                  r_cnt   <= A[SHW-1:0];
                  r_state <= (ALU_operation == OP_SRL) ? ST_SHIFT : ST_EXEC;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               r_res      <= w_res;
               r_zero     <= (w_res == {WIDTH{1'b0}});
               r_overflow <= w_ovf;
               r_state    <= ST_DONE;
            end
            ST_SHIFT: begin
               if (r_cnt == {SHW{1'b0}}) begin
                  r_res      <= r_shreg;
                  r_zero     <= (r_shreg == {WIDTH{1'b0}});
                  r_overflow <= 1'b0;
                  r_state    <= ST_DONE;
               end else begin
                  r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                  r_cnt   <= r_cnt - {{(SHW-1){1'b0}}, 1'b1};
                  r_state <= ST_SHIFT;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
